// File: rtl/riscv_test_monitor.sv
// riscv-tests completion monitor: shadows x3/x26/x27 and reports pass, fail or timeout.
// Define TEST_MON_JUMP_TRACE_EN to build the jump source/destination trace FIFO.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | first cycle after reset release
// RUN    | test running, cycle_cnt counting, watching for x26==1
// SETTLE | x26==1 seen, down-counter running before the x27 sample
// DONE   | verdict latched (pass or fail), terminal
// TOUT   | no x26==1 within TIMEOUT_CYCLES, terminal
module riscv_test_monitor #(
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        jump,
  input  logic [31:0] jump_src,
  input  logic [31:0] jump_dst,
  input  logic        trace_rd_en,
  output logic [63:0] trace_rd_data,
  output logic        trace_empty,
  output logic        trace_ovf,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] testnum,
  output logic [31:0] cycle_cnt
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_DONE,
    S_TOUT
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [31:0]   x3_q, x27_q, cnt_q;
  logic          done_q, done_d, pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
  logic          cnt_run;
  logic          wr_x3, wr_x27, wr_x26_one;

  assign wr_x3      = wb_en && (wb_addr == 5'd3);
  assign wr_x27     = wb_en && (wb_addr == 5'd27);
  assign wr_x26_one = wb_en && (wb_addr == 5'd26) && (wb_data == 32'd1);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tout_d   = tout_q;
    cnt_run  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        cnt_run = 1'b1;
        // x26 completion takes priority over a coincident timeout
        if (wr_x26_one) begin
          state_d  = S_SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_TOUT;
          tout_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (x27_q == 32'd1);
          fail_d  = (x27_q != 32'd1);
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_TOUT:  state_d = S_TOUT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
      x3_q     <= '0;
      x27_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tout_q   <= tout_d;
      if (cnt_run && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
      if (wr_x3)  x3_q  <= wb_data;
      if (wr_x27) x27_q <= wb_data;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = tout_q;
  assign testnum   = x3_q;
  assign cycle_cnt = cnt_q;

`ifdef TEST_MON_JUMP_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);

  logic [63:0] mem [TRACE_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push_req, push, pop, ovf_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = jump && (state_q != S_IDLE);
  assign pop      = trace_rd_en && !empty;
  // when full, a same-cycle pop frees the slot being written
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {jump_src, jump_dst};
  end

  assign trace_rd_data = empty ? 64'd0 : mem[rd_ptr[AW-1:0]];
  assign trace_empty   = empty;
  assign trace_ovf     = ovf_q;
`else
  logic unused_trace;
  assign unused_trace  = ^{jump, jump_src, jump_dst, trace_rd_en};
  assign trace_rd_data = 64'd0;
  assign trace_empty   = 1'b1;
  assign trace_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor; trace checks follow TEST_MON_JUMP_TRACE_EN.
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_src = '0;
  logic [31:0] jump_dst = '0;
  logic        trace_rd_en = 1'b0;
  logic [63:0] trace_rd_data;
  logic        trace_empty, trace_ovf, done, pass, fail, timeout;
  logic [31:0] testnum, cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  riscv_test_monitor dut (
    .clk(clk), .rstn(rstn), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump(jump), .jump_src(jump_src), .jump_dst(jump_dst), .trace_rd_en(trace_rd_en),
    .trace_rd_data(trace_rd_data), .trace_empty(trace_empty), .trace_ovf(trace_ovf),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .testnum(testnum), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // leaves rstn released 1 ns after an edge; the next edge is the IDLE cycle
  task automatic do_reset();
    rstn = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    jump = 1'b0; jump_src = '0; jump_dst = '0; trace_rd_en = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, timeout});
    end
    n_cmp++;
    if ({testnum, cycle_cnt} !== 64'd0) begin
      n_err++; $display("FAIL reset_regs testnum=%0d cycle_cnt=%0d exp 0/0", testnum, cycle_cnt);
    end
    n_cmp++;
    if ({trace_empty, trace_ovf, trace_rd_data} !== {2'b10, 64'd0}) begin
      n_err++; $display("FAIL reset_trace empty=%b ovf=%b data=%h exp 1/0/0", trace_empty, trace_ovf, trace_rd_data);
    end
    do_reset();
    tick();
    n_cmp++;
    if (cycle_cnt !== 32'd0) begin
      n_err++; $display("FAIL idle_cnt got=%0d exp=0", cycle_cnt);
    end
    tick();
    n_cmp++;
    if (cycle_cnt !== 32'd1) begin
      n_err++; $display("FAIL run_cnt got=%0d exp=1", cycle_cnt);
    end
  endtask

  task automatic test_pass();
    do_reset();
    wb(5'd3, 32'd5);
    wb(5'd27, 32'd1);
    repeat (39) tick();
    n_cmp++;
    if (cycle_cnt !== 32'd40) begin
      n_err++; $display("FAIL pass_cnt40 got=%0d exp=40", cycle_cnt);
    end
    wb(5'd26, 32'd1);
    repeat (4) tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL pass_early done=%b exp=0", done);
    end
    tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1100) begin
      n_err++; $display("FAIL pass_verdict got=%b exp=1100", {done, pass, fail, timeout});
    end
    n_cmp++;
    if (testnum !== 32'd5) begin
      n_err++; $display("FAIL pass_testnum got=%0d exp=5", testnum);
    end
    repeat (3) tick();
    n_cmp++;
    if ({done, pass, cycle_cnt} !== {2'b11, 32'd41}) begin
      n_err++; $display("FAIL pass_frozen done=%b pass=%b cnt=%0d exp 1/1/41", done, pass, cycle_cnt);
    end
  endtask

  task automatic test_fail();
    do_reset();
    wb(5'd3, 32'd7);
    wb(5'd27, 32'd0);
    wb(5'd26, 32'd1);
    repeat (5) tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_err++; $display("FAIL fail_verdict got=%b exp=1010", {done, pass, fail, timeout});
    end
    n_cmp++;
    if (testnum !== 32'd7) begin
      n_err++; $display("FAIL fail_testnum got=%0d exp=7", testnum);
    end
    wb(5'd27, 32'd1);
    wb(5'd26, 32'd1);
    wb(5'd3, 32'd9);
    tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_err++; $display("FAIL fail_sticky got=%b exp=1010", {done, pass, fail, timeout});
    end
    n_cmp++;
    if (testnum !== 32'd9) begin
      n_err++; $display("FAIL fail_x3_track got=%0d exp=9", testnum);
    end
  endtask

  task automatic test_late_x27();
    do_reset();
    wb(5'd3, 32'd1);
    wb(5'd26, 32'd1);
    tick();
    wb(5'd27, 32'd1);
    repeat (2) tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL late_early done=%b exp=0", done);
    end
    tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1100) begin
      n_err++; $display("FAIL late_verdict got=%b exp=1100", {done, pass, fail, timeout});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (1000) tick();
    n_cmp++;
    if ({timeout, cycle_cnt} !== {1'b0, 32'd999}) begin
      n_err++; $display("FAIL tout_pre timeout=%b cnt=%0d exp 0/999", timeout, cycle_cnt);
    end
    tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1001) begin
      n_err++; $display("FAIL tout_verdict got=%b exp=1001", {done, pass, fail, timeout});
    end
    wb(5'd27, 32'd1);
    wb(5'd26, 32'd1);
    repeat (6) tick();
    n_cmp++;
    if ({done, pass, fail, timeout, cycle_cnt} !== {4'b1001, 32'd1000}) begin
      n_err++; $display("FAIL tout_terminal flags=%b cnt=%0d exp 1001/1000", {done, pass, fail, timeout}, cycle_cnt);
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    repeat (1000) tick();
    wb(5'd26, 32'd1);
    n_cmp++;
    if ({timeout, done, cycle_cnt} !== {2'b00, 32'd1000}) begin
      n_err++; $display("FAIL race_settle timeout=%b done=%b cnt=%0d exp 0/0/1000", timeout, done, cycle_cnt);
    end
    repeat (5) tick();
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_err++; $display("FAIL race_verdict got=%b exp=1010", {done, pass, fail, timeout});
    end
  endtask

  task automatic test_x0();
    do_reset();
    wb(5'd3, 32'd4);
    wb(5'd0, 32'd1);
    wb(5'd0, 32'd1);
    n_cmp++;
    if (testnum !== 32'd4) begin
      n_err++; $display("FAIL x0_testnum got=%0d exp=4", testnum);
    end
    repeat (8) tick();
    n_cmp++;
    if ({done, cycle_cnt} !== {1'b0, 32'd10}) begin
      n_err++; $display("FAIL x0_run done=%b cnt=%0d exp 0/10", done, cycle_cnt);
    end
    wb(5'd26, 32'd1);
    repeat (5) tick();
    n_cmp++;
    if ({done, pass, fail} !== 3'b101) begin
      n_err++; $display("FAIL x0_x27 got=%b exp=101", {done, pass, fail});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wb(5'd3, 32'd5);
    wb(5'd27, 32'd1);
    wb(5'd26, 32'd1);
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({done, pass, testnum, cycle_cnt} !== {2'b00, 64'd0}) begin
      n_err++; $display("FAIL async_settle done=%b pass=%b testnum=%0d cnt=%0d exp all 0", done, pass, testnum, cycle_cnt);
    end
    do_reset();
    wb(5'd27, 32'd1);
    wb(5'd26, 32'd1);
    repeat (5) tick();
    n_cmp++;
    if ({done, pass} !== 2'b11) begin
      n_err++; $display("FAIL async_predone got=%b exp=11", {done, pass});
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({done, pass, fail, timeout} !== 4'b0000) begin
      n_err++; $display("FAIL async_done got=%b exp=0000", {done, pass, fail, timeout});
    end
  endtask

`ifdef TEST_MON_JUMP_TRACE_EN
  task automatic test_trace();
    logic [63:0] exp;
    do_reset();
    jump = 1'b1; jump_src = 32'hDEAD; jump_dst = 32'hBEEF;
    tick();
    jump = 1'b0;
    n_cmp++;
    if (trace_empty !== 1'b1) begin
      n_err++; $display("FAIL trace_idle empty=%b exp=1", trace_empty);
    end
    for (int k = 0; k < 9; k++) begin
      jump = 1'b1; jump_src = 32'h100 + 4 * k; jump_dst = 32'h200 + 4 * k;
      tick();
    end
    jump = 1'b0;
    n_cmp++;
    if ({trace_empty, trace_ovf} !== 2'b01) begin
      n_err++; $display("FAIL trace_ovf empty=%b ovf=%b exp 0/1", trace_empty, trace_ovf);
    end
    n_cmp++;
    if (trace_rd_data !== {32'h100, 32'h200}) begin
      n_err++; $display("FAIL trace_head got=%h exp=%h", trace_rd_data, {32'h100, 32'h200});
    end
    trace_rd_en = 1'b1; jump = 1'b1; jump_src = 32'h300; jump_dst = 32'h400;
    tick();
    trace_rd_en = 1'b0; jump = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp = (i < 8) ? {32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i)} : {32'h300, 32'h400};
      n_cmp++;
      if (trace_rd_data !== exp) begin
        n_err++; $display("FAIL trace_entry%0d got=%h exp=%h", i, trace_rd_data, exp);
      end
      trace_rd_en = 1'b1;
      tick();
      trace_rd_en = 1'b0;
    end
    n_cmp++;
    if ({trace_empty, trace_rd_data} !== {1'b1, 64'd0}) begin
      n_err++; $display("FAIL trace_drained empty=%b data=%h exp 1/0", trace_empty, trace_rd_data);
    end
    trace_rd_en = 1'b1;
    tick();
    trace_rd_en = 1'b0;
    jump = 1'b1; jump_src = 32'h500; jump_dst = 32'h600;
    tick();
    jump = 1'b0;
    n_cmp++;
    if ({trace_empty, trace_ovf, trace_rd_data} !== {2'b01, 32'h500, 32'h600}) begin
      n_err++; $display("FAIL trace_empty_pop empty=%b ovf=%b data=%h exp 0/1/500_600", trace_empty, trace_ovf, trace_rd_data);
    end
  endtask
`else
  task automatic test_trace();
    do_reset();
    tick();
    repeat (3) begin
      jump = 1'b1; jump_src = 32'h100; jump_dst = 32'h200; trace_rd_en = 1'b1;
      tick();
    end
    jump = 1'b0; trace_rd_en = 1'b0;
    n_cmp++;
    if ({trace_empty, trace_ovf, trace_rd_data} !== {2'b10, 64'd0}) begin
      n_err++; $display("FAIL trace_off empty=%b ovf=%b data=%h exp 1/0/0", trace_empty, trace_ovf, trace_rd_data);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_late_x27();
    test_timeout();
    test_timeout_race();
    test_x0();
    test_async_reset();
    test_trace();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
